// File: rtl/hsi_pkg.sv
// Shared types and width helpers for the HSI gyro-link receiver.
package hsi_pkg;

    // Receiver framing states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } hsi_state_e;

    // Default build of the gyro link.
    localparam int DEF_WORD_W      = 32;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT_CYC = 1024;

    // Bits needed to count 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed for an occupancy value 0..depth.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hsi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// A write into a full FIFO is only taken when a read happens in the same cycle.
module hsi_sync_fifo
    import hsi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = lvl_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == LVL_W'(DEPTH));
    assign do_pop  = rd_en_i && valid_o;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign do_push = wr_en_i && (!full_o || do_pop);

    // Head word is presented directly; zero while empty so stale data never shows.
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o   = count_q;

    // Storage array, written only for accepted words.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hsi_deserializer.sv
// HSI serial-to-parallel receiver: synchronises HSCK/HSDATA, detects the
// sampling edge, frames MSB-first words and queues them in an output FIFO.
module hsi_deserializer
    import hsi_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          hsck_pol,
    input  logic                          hsck,
    input  logic                          hsdata,
    output logic [WORD_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          timeout,
    input  logic                          clear_err
);
    localparam int CNT_W  = cnt_width(WORD_W);
    localparam int LVL_W  = lvl_width(FIFO_DEPTH);
    localparam int IDLE_W = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] hsck_sync_q;
    logic [SYNC_STAGES-1:0] hsdata_sync_q;
    logic                   sync_hsck;
    logic                   sync_hsdata;
    logic                   pol_ck;
    logic                   prev_pol_ck_q;
    logic                   sample;
    hsi_state_e             state_q, state_d;
    logic                   shifting;
    logic [WORD_W-1:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic                   timeout_q, timeout_d;
    logic                   overflow_q;
    logic [WORD_W-1:0]      word_next;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic [LVL_W-1:0]       level;

    // Synchroniser chains for the asynchronous serial pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            hsck_sync_q   <= '0;
            hsdata_sync_q <= '0;
        end else begin
            hsck_sync_q   <= {hsck_sync_q[SYNC_STAGES-2:0], hsck};
            hsdata_sync_q <= {hsdata_sync_q[SYNC_STAGES-2:0], hsdata};
        end
    end

    assign sync_hsck   = hsck_sync_q[SYNC_STAGES-1];
    assign sync_hsdata = hsdata_sync_q[SYNC_STAGES-1];
    // Fold the polarity in so the sampling edge is always a 0->1 of pol_ck.
    assign pol_ck      = ~(sync_hsck ^ hsck_pol);
    assign sample      = pol_ck & ~prev_pol_ck_q;

    // prev_pol_ck follows pol_ck every cycle, so edges seen while idle are absorbed.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_pol_ck_q <= 1'b0;
        end else begin
            prev_pol_ck_q <= pol_ck;
        end
    end

    // Framing state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enable alone moves between idle and shifting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable)  state_d = ST_SHIFT;
            ST_SHIFT: if (!enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign shifting  = (state_q == ST_SHIFT) && enable;
    assign word_next = {shreg_q[WORD_W-2:0], sync_hsdata};
    assign push      = shifting && sample && (bitcnt_q == LAST_BIT);
    assign pop       = m_valid && m_ready;

    // Shift, bit counting and idle timeout; leaving SHIFT drops the partial word.
    always_comb begin
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        idle_d    = idle_q;
        timeout_d = 1'b0;
        if (!shifting) begin
            bitcnt_d = '0;
            idle_d   = '0;
        end else if (sample) begin
            shreg_d  = word_next;
            idle_d   = '0;
            bitcnt_d = (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + 1'b1;
        end else if (bitcnt_q != '0) begin
            if (idle_q == IDLE_LAST) begin
                bitcnt_d  = '0;
                idle_d    = '0;
                timeout_d = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else begin
            idle_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    // Sticky overflow: a dropped word wins over a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end else if (clear_err) begin
            overflow_q <= 1'b0;
        end
    end

    hsi_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (push),
        .wr_data_i (word_next),
        .rd_en_i   (m_ready),
        .rd_data_o (m_data),
        .valid_o   (m_valid),
        .full_o    (fifo_full),
        .level_o   (level)
    );

    assign fifo_level = level;
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_hsi_deserializer.sv
// Directed bench for the HSI receiver with a cycle-level behavioural model.
module tb_hsi_deserializer;
    localparam int WORD_W      = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 1024;

    logic        clock = 1'b0;
    logic        reset, enable, hsck_pol, hsck, hsdata, m_ready, clear_err;
    logic        m_valid, overflow, timeout;
    logic [31:0] m_data;
    logic [2:0]  fifo_level;

    always #5 clock = ~clock;

    hsi_deserializer #(
        .WORD_W      (WORD_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .hsck_pol   (hsck_pol),
        .hsck       (hsck),
        .hsdata     (hsdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .timeout    (timeout),
        .clear_err  (clear_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: pending samples, partial word, output queue, flags.
    typedef struct {
        int   t;
        logic b;
    } ev_t;
    ev_t         ev[$];
    logic [31:0] mq[$];
    logic [31:0] part = '0;
    int          pn = 0;
    int          last_s = 0;
    int          cyc = 0;
    bit          ovf_m = 1'b0;
    bit          to_m = 1'b0;
    logic        hsck_seen = 1'b0;
    logic [31:0] got[$];
    int          to_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Model of one clock edge, derived from the pin-level rules: an active hsck
    // transition becomes a shifted bit SYNC_STAGES edges after it is registered.
    task automatic model_step();
        bit          pop, push, ovf_set;
        logic [31:0] pw;
        ev_t         e;
        cyc++;
        to_m    = 1'b0;
        push    = 1'b0;
        ovf_set = 1'b0;
        pw      = '0;
        if (reset) begin
            mq.delete();
            ev.delete();
            pn        = 0;
            ovf_m     = 1'b0;
            hsck_seen = hsck;
            return;
        end
        pop = (mq.size() != 0) && m_ready;
        if (hsck !== hsck_seen) begin
            if (enable && hsck == hsck_pol) begin
                e.t = cyc + SYNC_STAGES;
                e.b = hsdata;
                ev.push_back(e);
            end
            hsck_seen = hsck;
        end
        if (!enable) begin
            pn = 0;
            ev.delete();
        end else if (ev.size() != 0 && ev[0].t == cyc) begin
            part   = {part[30:0], ev[0].b};
            pn++;
            last_s = cyc;
            void'(ev.pop_front());
            if (pn == WORD_W) begin
                push = 1'b1;
                pw   = part;
                pn   = 0;
            end
        end else if (pn != 0 && (cyc - last_s) == TIMEOUT_CYC) begin
            pn   = 0;
            to_m = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back(pw);
            else ovf_set = 1'b1;
        end
        if (ovf_set) ovf_m = 1'b1;
        else if (clear_err) ovf_m = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic compare_step();
        check("m_valid", m_valid, (mq.size() != 0));
        if (mq.size() != 0) check("m_data", m_data, mq[0]);
        check("fifo_level", fifo_level, mq.size());
        check("overflow", overflow, ovf_m);
        check("timeout", timeout, to_m);
        if (timeout === 1'b1) to_seen++;
        if (m_valid === 1'b1 && m_ready === 1'b1) got.push_back(m_data);
    endtask

    // Advance n cycles: compare on the falling edge, step the model on the
    // rising edge, and return 2 time units later so inputs change off-edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            compare_step();
            @(posedge clock);
            model_step();
            #2;
        end
    endtask

    // Serial bits MSB first; act is the hsck level reached on the sampling half.
    task automatic send(input logic [63:0] w, input int n, input logic act);
        for (int i = n - 1; i >= 0; i--) begin
            hsdata = w[i];
            hsck   = ~act;
            tick(4);
            hsck   = act;
            tick(4);
        end
    endtask

    task automatic expect_word(input string name, input logic [31:0] exp);
        int k = 0;
        while (got.size() == 0 && k < 64) begin
            tick(1);
            k++;
        end
        if (got.size() == 0) check({name, "_wait"}, 64'd0, 64'd1);
        else check(name, got.pop_front(), exp);
    endtask

    task automatic go_idle_set_pol(input logic pol, input logic idle_ck);
        enable = 1'b0;
        tick(2);
        hsck = idle_ck;
        tick(2);
        hsck_pol = pol;
        tick(4);
        enable = 1'b1;
        tick(3);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; hsck_pol = 1'b1; hsck = 1'b0;
        hsdata = 1'b0; m_ready = 1'b1; clear_err = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout, 0);
        $display("[TB] reset checked");
        enable = 1'b1;
        tick(3);

        // Rising-edge word with exact latency.
        send(64'hA5C30F81 >> 1, 31, 1'b1);
        hsdata = 1'b1; hsck = 1'b0;
        tick(4);
        hsck = 1'b1;
        tick(2);
        check("t1_valid_early", m_valid, 0);
        tick(1);
        check("t1_valid_latency", m_valid, 1);
        check("t1_word", m_data, 32'hA5C30F81);
        expect_word("t1_pop", 32'hA5C30F81);
        $display("[TB] word rising edge done");

        // Falling-edge sampling, then misaligned drive.
        go_idle_set_pol(1'b0, 1'b1);
        send(64'hA5C30F81, 32, 1'b0);
        expect_word("t2_fall", 32'hA5C30F81);
        send(64'h1_4B86_1F02, 33, 1'b1);
        expect_word("t2_shifted", 32'h4B861F02);
        $display("[TB] falling edge and shifted word done");
        go_idle_set_pol(1'b1, 1'b0);

        // Overflow with a stalled consumer.
        m_ready = 1'b0;
        for (int w = 1; w <= 5; w++) send(64'(w), 32, 1'b1);
        tick(6);
        check("t3_level", fifo_level, 4);
        check("t3_overflow", overflow, 1);
        check("t3_head", m_data, 1);
        m_ready = 1'b1;
        for (int w = 1; w <= 4; w++) expect_word("t3_drain", 32'(w));
        tick(6);
        check("t3_no_fifth", got.size(), 0);
        check("t3_sticky", overflow, 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("t3_cleared", overflow, 0);
        $display("[TB] overflow done");

        // Full FIFO with a pop on the exact push edge.
        m_ready = 1'b0;
        for (int w = 1; w <= 4; w++) send(64'(w), 32, 1'b1);
        send(64'd5 >> 1, 31, 1'b1);
        hsdata = 1'b1; hsck = 1'b0;
        tick(4);
        hsck = 1'b1;
        tick(2);
        m_ready = 1'b1;
        tick(1);
        check("t4_level_full", fifo_level, 4);
        check("t4_no_overflow", overflow, 0);
        for (int w = 1; w <= 5; w++) expect_word("t4_drain", 32'(w));
        $display("[TB] push+pop on full done");

        // Timeout on a partial word, then realignment.
        to_seen = 0;
        send(64'h2A5, 10, 1'b1);
        tick(TIMEOUT_CYC + 20);
        check("t5_timeout_pulses", to_seen, 1);
        check("t5_no_word", got.size(), 0);
        send(64'hDEADBEEF, 32, 1'b1);
        expect_word("t5_realigned", 32'hDEADBEEF);
        $display("[TB] timeout done");

        // Disable mid-word, toggle polarity while idle, then a clean word.
        send(64'hBEEF, 16, 1'b1);
        enable = 1'b0;
        tick(4);
        hsck_pol = 1'b0;
        tick(4);
        hsck_pol = 1'b1;
        tick(4);
        enable = 1'b1;
        tick(3);
        check("t6_nothing_queued", fifo_level, 0);
        send(64'h12345678, 32, 1'b1);
        expect_word("t6_aligned", 32'h12345678);
        tick(10);
        check("t6_no_extra", got.size(), 0);
        $display("[TB] enable drop and pol toggle done");

        // Reset with words queued and a partial word in flight.
        m_ready = 1'b0;
        send(64'h11, 32, 1'b1);
        send(64'h22, 32, 1'b1);
        send(64'h15, 5, 1'b1);
        hsck = 1'b0;
        tick(6);
        check("t7_level_before", fifo_level, 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        check("t7_level", fifo_level, 0);
        check("t7_valid", m_valid, 0);
        check("t7_data", m_data, 0);
        m_ready = 1'b1;
        send(64'hCAFEF00D, 32, 1'b1);
        expect_word("t7_after_reset", 32'hCAFEF00D);
        $display("[TB] reset mid-traffic done");

        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
